// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide,
// STEP bits per cycle, with single-cycle handling of divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [2:0]      in_op,
  input  logic            in_word32,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = (XLEN / STEP > 1) ? $clog2(XLEN / STEP) : 1;
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(32 / STEP - 1);
  localparam logic [CNT_W-1:0] LAST_X = CNT_W'(XLEN / STEP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
    logic signed [31:0] sv;
    sv = v;
    return s ? XLEN'(sv) : XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] v);
    return w ? ext32(v[31:0], 1'b1) : v;
  endfunction

  // Applies the recorded signs to the unsigned magnitudes and picks the result half.
  function automatic logic [XLEN-1:0] finish_res(
    input logic [2:0]        op,
    input logic              w,
    input logic              nq,
    input logic              nr,
    input logic [2*XLEN-1:0] acc,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   r;
    logic [XLEN-1:0]   v;
    prod = nq ? -acc : acc;
    q    = nq ? -quo : quo;
    r    = nr ? -rem : rem;
    case (op)
      OP_MUL:                      v = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: v = w ? XLEN'(prod[63:32]) : prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             v = q;
      default:                     v = r;
    endcase
    return sext_w(w, v);
  endfunction

  logic [1:0]          state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                w_q, w_d;
  logic                neg_q, neg_d;
  logic                negr_q, negr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     dvs_q, dvs_d;
  logic [XLEN-1:0]     res_q, res_d;

  logic                sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag, min_n, spec_res;
  logic                b_zero, ovf, special;

  logic [2*XLEN-1:0]   acc_n;
  logic [XLEN-1:0]     quo_n;
  logic [XLEN:0]       rem_n;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;

  // Operand preparation for the op currently offered on the input.
  always_comb begin
    sgn_a   = (in_op != OP_MULHU) && (in_op != OP_DIVU) && (in_op != OP_REMU);
    sgn_b   = sgn_a && (in_op != OP_MULHSU);
    a_ext   = in_word32 ? ext32(in_a[31:0], sgn_a) : in_a;
    b_ext   = in_word32 ? ext32(in_b[31:0], sgn_b) : in_b;
    a_neg   = sgn_a & a_ext[XLEN-1];
    b_neg   = sgn_b & b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    min_n   = in_word32 ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (b_ext == '0);
    ovf     = sgn_b && (a_ext == min_n) && (b_ext == '1);
    special = in_op[2] && (b_zero || ovf);
    case (in_op)
      OP_DIV, OP_DIVU: spec_res = b_zero ? '1 : a_ext;
      default:         spec_res = b_zero ? a_ext : '0;
    endcase
    spec_res = sext_w(in_word32, spec_res);
  end

  // One iteration: STEP multiplier bits added in, or STEP restoring quotient bits.
  always_comb begin
    acc_n = acc_q;
    for (int k = 0; k < STEP; k++) begin
      if (mplier_q[k]) acc_n = acc_n + (mcand_q << k);
    end
    quo_n = quo_q;
    rem_n = rem_q;
    for (int k = 0; k < STEP; k++) begin
      rem_n = {rem_n[XLEN-1:0], quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      if (rem_n >= {1'b0, dvs_q}) begin
        rem_n    = rem_n - {1'b0, dvs_q};
        quo_n[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    w_d      = w_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d     = in_op;
            w_d      = in_word32;
            neg_d    = a_neg ^ b_neg;
            negr_d   = a_neg;
            cnt_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            // Dividend is left-aligned so W ops shift their 32 bits out first.
            quo_d    = in_word32 ? (a_mag << (XLEN - 32)) : a_mag;
            rem_d    = '0;
            dvs_d    = b_mag;
            if (special) begin
              res_d   = spec_res;
              state_d = S_DONE;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!op_q[2]) begin
            acc_d    = acc_n;
            mcand_d  = mcand_q << STEP;
            mplier_d = mplier_q >> STEP;
          end else begin
            quo_d = quo_n;
            rem_d = rem_n;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == (w_q ? LAST_W : LAST_X)) begin
            res_d   = finish_res(op_q, w_q, neg_q, negr_q, acc_n, quo_n, rem_n[XLEN-1:0]);
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      w_q      <= w_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// checked against a plain-arithmetic RV64M reference model.
module tb_muldiv_unit;
  localparam int XLEN = 64;
  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic        in_word32 = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_word32(in_word32),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic w);
    logic [127:0] p;
    longint       sa, sb;
    int           a32, b32;
    logic [31:0]  r32;
    logic [63:0]  r;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0];
    r32 = '0; r = '0; p = '0;
    if (w) begin
      case (op)
        3'd0: r32 = a[31:0] * b[31:0];
        3'd4: if (b[31:0] == 0) r32 = '1;
              else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
              else r32 = a32 / b32;
        3'd5: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'd6: if (b[31:0] == 0) r32 = a[31:0];
              else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = '0;
              else r32 = a32 % b32;
        3'd7: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = '0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (op)
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
            else r = sa / sb;
      3'd5: if (b == 0) r = '1; else r = a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
            else r = sa % sb;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic int lat_model(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input logic w);
    logic bz, ov;
    bz = w ? (b[31:0] == 0) : (b == 0);
    ov = (op == 3'd4 || op == 3'd6) &&
         (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
            : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (op[2] && (bz || ov)) return 1;
    return (w ? 32 : 64) / STEP + 1;
  endfunction

  task automatic accept(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic w);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_word32 = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic w, input logic [63:0] exp,
                        input int lat_exp);
    int lat;
    accept(op, a, b, w);
    wait_valid(tag, lat);
    chk({tag, "/lat"}, 64'(lat), 64'(lat_exp));
    chk({tag, "/res"}, result, exp);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "/idle"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return 64'($urandom_range(0, 40));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int lat;
    logic seen;
    logic [2:0] op;
    logic w;
    logic [63:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/in_ready", 64'(in_ready), 64'd1);
    chk("rst/out_valid", 64'(out_valid), 64'd0);
    chk("rst/result", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul", 3'd0, '1, 64'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("mulhu", 3'd3, '1, 64'd3, 1'b0, 64'h0000_0000_0000_0002, 65);
    run_op("div", 3'd4, -64'sd7, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem", 3'd6, -64'sd7, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu", 3'd5, 64'd7, 64'd2, 1'b0, 64'd3, 65);
    run_op("div_ovf", 3'd4, 64'h8000_0000_0000_0000, '1, 1'b0, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 3'd6, 64'h8000_0000_0000_0000, '1, 1'b0, 64'd0, 1);
    run_op("divu_z", 3'd5, 64'd5, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_z", 3'd7, 64'd5, 64'd0, 1'b0, 64'd5, 1);
    run_op("divuw", 3'd5, 64'hFFFF_FFFF_8000_0000, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 33);
    run_op("mulw", 3'd0, 64'h7FFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // Result held while the consumer stalls.
    accept(3'd4, 64'd100, 64'd7, 1'b0);
    wait_valid("hold", lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d/valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d/res", i), result, 64'd14);
      chk($sformatf("hold%0d/in_ready", i), 64'(in_ready), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Flush in the middle of an iteration run.
    accept(3'd0, 64'd123, 64'd456, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy/in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy/out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_busy/never_valid", 64'(seen), 64'd0);

    // Flush alongside in_valid blocks the accept.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd5; in_a = 64'd9; in_b = 64'd0; in_word32 = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc/in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_acc/out_valid", 64'(out_valid), 64'd0);

    // Flush together with out_ready in DONE.
    accept(3'd5, 64'd5, 64'd0, 1'b0);
    wait_valid("flush_done", lat);
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
    chk("flush_done/out_valid", 64'(out_valid), 64'd0);
    chk("flush_done/in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset during iteration 20.
    accept(3'd0, 64'd77, 64'd99, 1'b0);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst/out_valid", 64'(out_valid), 64'd0);
    chk("arst/in_ready", 64'(in_ready), 64'd1);
    chk("arst/result", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 3'd5, 64'd7, 64'd2, 1'b0, 64'd3, 65);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      if (w && op inside {3'd1, 3'd2, 3'd3}) w = 1'b0;
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d_op%0d_w%0d", i, op, w), op, a, b, w,
             ref_model(op, a, b, w), lat_model(op, a, b, w));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
